lsu: RTL and testbench

Memory-access stage of the NPC core, between the execute unit and `wbu`. Accepts one instruction at a time from execute over a valid/ready handshake. For loads and stores it runs a single-beat transaction on the data-memory bus, aligning and extending load data. It then presents the instruction's fields to `wbu` with a one-cycle `wb_en_o` pulse.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_if.sv | 24 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 177 +++++++++++++++++
 tb/tb_lsu.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Purpose : shared widths, funct3 memop encodings, FSM states and helpers for the NPC memory-access stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: XLEN/REG_W/PC_W/IMM_W/RS_W/SYS_W widths, F3_* memop codes, lsu_state_e, misaligned().
package lsu_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 32;
    localparam int PC_W  = 32;
    localparam int IMM_W = 32;
    localparam int RS_W  = 5;
    localparam int SYS_W = 4;

    // Load and store funct3 codes share the same encoding space.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Halfword ops (LH/LHU/SH all have funct3[1:0]==01) need an even offset;
    // word ops need offset 0.
    function automatic logic misaligned(input logic [2:0] memop, input logic [1:0] off);
        return ((memop[1:0] == 2'b01) && off[0]) ||
               ((memop == F3_LW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Purpose : single-beat data-memory bus between lsu (master) and memory (slave).
// Latency : n/a (wires only).
// Backpressure: request held until mem_req_ready_i; response signalled by mem_rsp_valid_i.
// Signals: request valid/ready, word address, write enable, write data, byte strobes, response valid, read data.
interface lsu_if;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o,
        input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o,
        output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_align.sv
// Purpose : store lane replication/strobes and load shift/extension for one memop.
// Latency : purely combinational.
// Backpressure: none.
// Ports: i_memop, i_off, i_wdata, i_rdata -> o_st_data, o_st_strb, o_ld_data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_memop,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_st_data,
    output logic [3:0]      o_st_strb,
    output logic [XLEN-1:0] o_ld_data
);
    logic [XLEN-1:0] w_shifted;

    // Bring the addressed byte/halfword down to bit 0 before extending.
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_st_data = i_wdata;
        o_st_strb = 4'b1111;
        case (i_memop)
            F3_SB: begin
                o_st_data = {4{i_wdata[7:0]}};
                o_st_strb = 4'b0001 << i_off;
            end
            F3_SH: begin
                o_st_data = {2{i_wdata[15:0]}};
                o_st_strb = 4'b0011 << i_off;
            end
            default: begin
                o_st_data = i_wdata;
                o_st_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        o_ld_data = w_shifted;
        case (i_memop)
            F3_LB:   o_ld_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            F3_LH:   o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_ld_data = {24'h0, w_shifted[7:0]};
            F3_LHU:  o_ld_data = {16'h0, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Purpose : NPC memory-access stage; runs one bus beat for loads/stores and pulses wb_en_o to wbu.
// Latency : non-mem op wb_en_o at T+1; mem op T+3 plus one cycle per stall cycle on either handshake.
// Backpressure: e_ready_o only in IDLE (one instruction in flight); request held until mem_req_ready_i.
// Ports: clock/reset, e_* from execute, mem (lsu_if.master), wb_en_o and m_* to wbu.
// Option : YSYX_23060251_LSU_ALIGN_CHECK_EN adds m_misalign_o and skips the bus for misaligned ops.
module lsu
    import lsu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             e_valid_i,
    output logic             e_ready_o,
    input  logic             e_wenReg_i,
    input  logic             e_wenCsr_i,
    input  logic             e_renMem_i,
    input  logic             e_wenMem_i,
    input  logic [2:0]       e_memop_i,
    input  logic [RS_W-1:0]  e_rd_i,
    input  logic [XLEN-1:0]  e_res_i,
    input  logic [XLEN-1:0]  e_wdata_i,
    input  logic [SYS_W-1:0] e_sys_info_i,
    input  logic [IMM_W-1:0] e_imm_i,
    input  logic [REG_W-1:0] e_src1_i,
    input  logic [PC_W-1:0]  e_pc_i,
    input  logic [PC_W-1:0]  e_npc_i,
    lsu_if.master            mem,
    output logic             wb_en_o,
    output logic             m_wenReg_o,
    output logic             m_wenCsr_o,
    output logic             m_renMem_o,
    output logic [RS_W-1:0]  m_rd_o,
    output logic [XLEN-1:0]  m_res_o,
    output logic [XLEN-1:0]  m_rdata_o,
    output logic [SYS_W-1:0] m_sys_info_o,
    output logic [IMM_W-1:0] m_imm_o,
    output logic [REG_W-1:0] m_src1_o,
    output logic [PC_W-1:0]  m_pc_o,
    output logic [PC_W-1:0]  m_npc_o
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
    ,
    output logic             m_misalign_o
`endif
);
    lsu_state_e       r_state;
    logic             r_ready, r_req_vld, r_wb_en;
    logic             r_wenReg, r_wenCsr, r_renMem, r_wenMem;
    logic [2:0]       r_memop;
    logic [RS_W-1:0]  r_rd;
    logic [XLEN-1:0]  r_res, r_wdata, r_rdata;
    logic [SYS_W-1:0] r_sys;
    logic [IMM_W-1:0] r_imm;
    logic [REG_W-1:0] r_src1;
    logic [PC_W-1:0]  r_pc, r_npc;
    logic             w_is_mem, w_misalign;
    logic [XLEN-1:0]  w_st_data, w_ld_data;
    logic [3:0]       w_st_strb;

    assign w_is_mem = e_renMem_i | e_wenMem_i;

`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign   = w_is_mem & misaligned(e_memop_i, e_res_i[1:0]);
    assign m_misalign_o = r_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    // Alignment works from the latched fields so the bus request stays stable
    // for as long as the slave stalls.
    lsu_align u_align (
        .i_memop   (r_memop),
        .i_off     (r_res[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem.mem_rdata_i),
        .o_st_data (w_st_data),
        .o_st_strb (w_st_strb),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_req_vld <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wenReg  <= 1'b0;
            r_wenCsr  <= 1'b0;
            r_renMem  <= 1'b0;
            r_wenMem  <= 1'b0;
            r_memop   <= '0;
            r_rd      <= '0;
            r_res     <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_sys     <= '0;
            r_imm     <= '0;
            r_src1    <= '0;
            r_pc      <= '0;
            r_npc     <= '0;
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (e_valid_i) begin
                        r_ready  <= 1'b0;
                        r_wenReg <= e_wenReg_i & ~w_misalign;
                        r_wenCsr <= e_wenCsr_i;
                        r_renMem <= e_renMem_i;
                        r_wenMem <= e_wenMem_i;
                        r_memop  <= e_memop_i;
                        r_rd     <= e_rd_i;
                        r_res    <= e_res_i;
                        r_wdata  <= e_wdata_i;
                        r_rdata  <= '0;
                        r_sys    <= e_sys_info_i;
                        r_imm    <= e_imm_i;
                        r_src1   <= e_src1_i;
                        r_pc     <= e_pc_i;
                        r_npc    <= e_npc_i;
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
                        r_misalign <= w_misalign;
`endif
                        if (w_is_mem && !w_misalign) begin
                            r_state   <= S_REQ;
                            r_req_vld <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_wb_en <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready_i) begin
                        r_state   <= S_WAIT;
                        r_req_vld <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_rsp_valid_i) begin
                        if (r_renMem) begin
                            r_rdata <= w_ld_data;
                        end
                        r_state <= S_DONE;
                        r_wb_en <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_wb_en <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign e_ready_o           = r_ready;
    assign mem.mem_req_valid_o = r_req_vld;
    assign mem.mem_addr_o      = {r_res[31:2], 2'b00};
    assign mem.mem_wen_o       = r_wenMem;
    assign mem.mem_wdata_o     = w_st_data;
    // Strobes only mean something for writes; keeps them zero out of reset.
    assign mem.mem_wstrb_o     = w_st_strb & {4{r_wenMem}};
    assign wb_en_o             = r_wb_en;
    assign m_wenReg_o          = r_wenReg;
    assign m_wenCsr_o          = r_wenCsr;
    assign m_renMem_o          = r_renMem;
    assign m_rd_o              = r_rd;
    assign m_res_o             = r_res;
    assign m_rdata_o           = r_rdata;
    assign m_sys_info_o        = r_sys;
    assign m_imm_o             = r_imm;
    assign m_src1_o            = r_src1;
    assign m_pc_o              = r_pc;
    assign m_npc_o             = r_npc;
endmodule

// File: tb/tb_lsu.sv
// Purpose : self-checking bench for lsu; scoreboard of expected wbu results popped on wb_en_o.
// Latency : n/a.
// Backpressure: bus responder applies programmable request/response stalls.
module tb_lsu;
    import lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        e_valid_i, e_ready_o;
    logic        e_wenReg_i, e_wenCsr_i, e_renMem_i, e_wenMem_i;
    logic [2:0]  e_memop_i;
    logic [4:0]  e_rd_i;
    logic [31:0] e_res_i, e_wdata_i, e_imm_i, e_src1_i, e_pc_i, e_npc_i;
    logic [3:0]  e_sys_info_i;
    logic        wb_en_o, m_wenReg_o, m_wenCsr_o, m_renMem_o;
    logic [4:0]  m_rd_o;
    logic [31:0] m_res_o, m_rdata_o, m_imm_o, m_src1_o, m_pc_o, m_npc_o;
    logic [3:0]  m_sys_info_o;
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
    logic        m_misalign_o;
`endif

    lsu_if u_if ();

    lsu dut (
        .clock(clock), .reset(reset),
        .e_valid_i(e_valid_i), .e_ready_o(e_ready_o),
        .e_wenReg_i(e_wenReg_i), .e_wenCsr_i(e_wenCsr_i),
        .e_renMem_i(e_renMem_i), .e_wenMem_i(e_wenMem_i),
        .e_memop_i(e_memop_i), .e_rd_i(e_rd_i), .e_res_i(e_res_i),
        .e_wdata_i(e_wdata_i), .e_sys_info_i(e_sys_info_i), .e_imm_i(e_imm_i),
        .e_src1_i(e_src1_i), .e_pc_i(e_pc_i), .e_npc_i(e_npc_i),
        .mem(u_if),
        .wb_en_o(wb_en_o), .m_wenReg_o(m_wenReg_o), .m_wenCsr_o(m_wenCsr_o),
        .m_renMem_o(m_renMem_o), .m_rd_o(m_rd_o), .m_res_o(m_res_o),
        .m_rdata_o(m_rdata_o), .m_sys_info_o(m_sys_info_o), .m_imm_o(m_imm_o),
        .m_src1_o(m_src1_o), .m_pc_o(m_pc_o), .m_npc_o(m_npc_o)
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
        , .m_misalign_o(m_misalign_o)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res, rdata, pc;
        logic [4:0]  rd;
        logic        wreg, wcsr, rmem, mis;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    int          req_wait = 0, rsp_wait = 0, rq_cnt = 0, rs_cnt = 0;
    bit          pend = 0, rsp_enable = 1, bus_manual = 0;
    logic [31:0] rsp_data = 32'h0;

    initial begin
        u_if.mem_req_ready_i = 1'b0;
        u_if.mem_rsp_valid_i = 1'b0;
        u_if.mem_rdata_i     = 32'h0;
        forever begin
            @(negedge clock);
            if (!bus_manual) begin
                u_if.mem_req_ready_i = 1'b0;
                u_if.mem_rsp_valid_i = 1'b0;
                if (u_if.mem_req_valid_o === 1'b1) begin
                    if (rq_cnt >= req_wait) begin
                        u_if.mem_req_ready_i = 1'b1;
                        rq_cnt = 0; rs_cnt = 0; pend = 1;
                    end else rq_cnt++;
                end else if (pend && rsp_enable) begin
                    if (rs_cnt >= rsp_wait) begin
                        u_if.mem_rsp_valid_i = 1'b1;
                        u_if.mem_rdata_i     = rsp_data;
                        pend = 0;
                    end else rs_cnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (wb_en_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_wb_en: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("m_res", m_res_o, e.res);
                    chk("m_rdata", m_rdata_o, e.rdata);
                    chk("m_rd", 32'(m_rd_o), 32'(e.rd));
                    chk("m_wenReg", 32'(m_wenReg_o), 32'(e.wreg));
                    chk("m_wenCsr", 32'(m_wenCsr_o), 32'(e.wcsr));
                    chk("m_renMem", 32'(m_renMem_o), 32'(e.rmem));
                    chk("m_pc", m_pc_o, e.pc);
                    chk("m_npc", m_npc_o, e.pc + 32'd4);
                    chk("m_imm", m_imm_o, e.pc ^ 32'h55);
                    chk("m_src1", m_src1_o, ~e.pc);
                    chk("m_sys_info", 32'(m_sys_info_o), 32'(e.pc[5:2]));
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
                    chk("m_misalign", 32'(m_misalign_o), 32'(e.mis));
`endif
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic wreg, input logic wcsr, input logic rmem, input logic wmem,
                         input logic [2:0] op, input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] wdata, input logic [31:0] pc,
                         input bit expect_wb, input logic [31:0] x_rdata, input logic x_wreg,
                         input logic x_mis, input int lat, output int t_acc);
        exp_t e;
        int   guard = 0;
        @(negedge clock);
        while (e_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL issue_ready_timeout: got e_ready_o=%b expected 1", e_ready_o);
        end
        e_wenReg_i = wreg; e_wenCsr_i = wcsr; e_renMem_i = rmem; e_wenMem_i = wmem;
        e_memop_i = op; e_rd_i = rd; e_res_i = res; e_wdata_i = wdata;
        e_pc_i = pc; e_npc_i = pc + 32'd4; e_imm_i = pc ^ 32'h55; e_src1_i = ~pc;
        e_sys_info_i = pc[5:2];
        e_valid_i = 1'b1;
        t_acc = cyc;
        if (expect_wb) begin
            e.res = res; e.rdata = x_rdata; e.pc = pc; e.rd = rd;
            e.wreg = x_wreg; e.wcsr = wcsr; e.rmem = rmem; e.mis = x_mis;
            e.cyc = cyc + lat;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1 e_valid_i = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int guard = 0;
        @(negedge clock);
        while (e_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL %s_ready_timeout: got e_ready_o=%b expected 1", nm, e_ready_o);
        end
    endtask

    task automatic chk_req(input string nm, input logic vld, input logic [31:0] addr,
                           input logic wen, input logic [31:0] wdata, input logic [3:0] strb);
        chk({nm, "_req_valid"}, 32'(u_if.mem_req_valid_o), 32'(vld));
        chk({nm, "_addr"}, u_if.mem_addr_o, addr);
        chk({nm, "_wen"}, 32'(u_if.mem_wen_o), 32'(wen));
        if (wen) chk({nm, "_wdata"}, u_if.mem_wdata_o, wdata);
        chk({nm, "_wstrb"}, 32'(u_if.mem_wstrb_o), 32'(strb));
    endtask

    task automatic load(input string nm, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [31:0] x_rdata, input logic [31:0] pc);
        int a;
        rsp_data = rdata;
        issue(1'b1, 1'b0, 1'b1, 1'b0, op, 5'd7, addr, 32'h0, pc, 1'b1, x_rdata, 1'b1, 1'b0, 3, a);
        @(negedge clock);
        chk_req(nm, 1'b1, {addr[31:2], 2'b00}, 1'b0, 32'h0, 4'b0000);
        wait_ready(nm);
    endtask

    task automatic store(input string nm, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] x_wdata,
                         input logic [3:0] x_strb, input logic [31:0] pc);
        int a;
        issue(1'b0, 1'b0, 1'b0, 1'b1, op, 5'd0, addr, wdata, pc, 1'b1, 32'h0, 1'b0, 1'b0, 3, a);
        @(negedge clock);
        chk_req(nm, 1'b1, {addr[31:2], 2'b00}, 1'b1, x_wdata, x_strb);
        wait_ready(nm);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a;
        reset = 1'b1;
        e_valid_i = 1'b0; e_wenReg_i = 1'b0; e_wenCsr_i = 1'b0; e_renMem_i = 1'b0;
        e_wenMem_i = 1'b0; e_memop_i = 3'b0; e_rd_i = 5'd0; e_res_i = 32'h0;
        e_wdata_i = 32'h0; e_sys_info_i = 4'h0; e_imm_i = 32'h0; e_src1_i = 32'h0;
        e_pc_i = 32'h0; e_npc_i = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(e_ready_o), 32'd1);
        chk("rst_wb_en", 32'(wb_en_o), 32'd0);
        chk_req("rst", 1'b0, 32'h0, 1'b0, 32'h0, 4'b0000);
        chk("rst_wdata", u_if.mem_wdata_o, 32'h0);
        chk("rst_m_res", m_res_o, 32'h0);
        chk("rst_m_rdata", m_rdata_o, 32'h0);
        chk("rst_m_wenReg", 32'(m_wenReg_o), 32'd0);
`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
        chk("rst_m_misalign", 32'(m_misalign_o), 32'd0);
`endif
        reset = 1'b0;

        // Non-memory ALU op: wb_en at T+1, ready back at T+2.
        issue(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 32'h8000_0100,
              1'b1, 32'h0, 1'b1, 1'b0, 1, a);
        @(negedge clock);
        chk("add_ready_T1", 32'(e_ready_o), 32'd0);
        chk("add_req_T1", 32'(u_if.mem_req_valid_o), 32'd0);
        @(negedge clock);
        chk("add_ready_T2", 32'(e_ready_o), 32'd1);

        // CSR-writing non-memory op.
        issue(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 5'd3, 32'hCAFE_0001, 32'h0, 32'h8000_0104,
              1'b1, 32'h0, 1'b0, 1'b0, 1, a);
        wait_ready("csr");

        // Loads.
        load("lb",  F3_LB,  32'h8000_0003, 32'h80FF_FF7F, 32'hFFFF_FF80, 32'h8000_0108);
        load("lbu", F3_LBU, 32'h8000_0003, 32'h80FF_FF7F, 32'h0000_0080, 32'h8000_010C);
        load("lh",  F3_LH,  32'h8000_0002, 32'h8001_1234, 32'hFFFF_8001, 32'h8000_0110);
        load("lhu", F3_LHU, 32'h8000_0002, 32'h8001_1234, 32'h0000_8001, 32'h8000_0114);
        load("lw",  F3_LW,  32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0118);
        load("lb0", F3_LB,  32'h8000_0008, 32'h1234_5678, 32'h0000_0078, 32'h8000_011C);

        // Stores.
        store("sh", F3_SH, 32'h8000_0002, 32'hAAAA_BEEF, 32'hBEEF_BEEF, 4'b1100, 32'h8000_0120);
        store("sb", F3_SB, 32'h8000_0101, 32'h1234_565A, 32'h5A5A_5A5A, 4'b0010, 32'h8000_0124);

`ifdef YSYX_23060251_LSU_ALIGN_CHECK_EN
        // Misaligned LW bypasses the bus entirely.
        issue(1'b1, 1'b0, 1'b1, 1'b0, F3_LW, 5'd9, 32'h8000_0001, 32'h0, 32'h8000_0128,
              1'b1, 32'h0, 1'b0, 1'b1, 1, a);
        @(negedge clock);
        chk("mis_req_valid", 32'(u_if.mem_req_valid_o), 32'd0);
        wait_ready("mis");
`endif

        // Stalled SW: ready low 3 cycles, response 2 cycles late -> wb_en at T+8.
        req_wait = 3; rsp_wait = 2;
        issue(1'b0, 1'b0, 1'b0, 1'b1, F3_SW, 5'd0, 32'h8000_0010, 32'h1234_5678, 32'h8000_012C,
              1'b1, 32'h0, 1'b0, 1'b0, 8, a);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk_req($sformatf("stall_c%0d", k), 1'b1, 32'h8000_0010, 1'b1, 32'h1234_5678, 4'b1111);
        end
        @(negedge clock);
        chk("stall_req_drop", 32'(u_if.mem_req_valid_o), 32'd0);
        wait_ready("stall");
        req_wait = 0; rsp_wait = 0;

        // Reset while in WAIT: transaction abandoned, late response ignored.
        rsp_enable = 0;
        issue(1'b1, 1'b0, 1'b1, 1'b0, F3_LW, 5'd11, 32'h8000_0020, 32'h0, 32'h8000_0130,
              1'b0, 32'h0, 1'b0, 1'b0, 0, a);
        @(negedge clock);
        @(negedge clock);
        chk("wait_req_valid", 32'(u_if.mem_req_valid_o), 32'd0);
        chk("wait_ready", 32'(e_ready_o), 32'd0);
        bus_manual = 1;
        u_if.mem_req_ready_i = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        pend = 0;
        chk("wrst_ready", 32'(e_ready_o), 32'd1);
        chk("wrst_wb_en", 32'(wb_en_o), 32'd0);
        chk_req("wrst", 1'b0, 32'h0, 1'b0, 32'h0, 4'b0000);
        chk("wrst_wdata", u_if.mem_wdata_o, 32'h0);
        chk("wrst_m_res", m_res_o, 32'h0);
        chk("wrst_m_rd", 32'(m_rd_o), 32'd0);
        chk("wrst_m_pc", m_pc_o, 32'h0);
        chk("wrst_m_renMem", 32'(m_renMem_o), 32'd0);
        u_if.mem_rsp_valid_i = 1'b1;
        u_if.mem_rdata_i     = 32'h5555_AAAA;
        repeat (2) @(negedge clock);
        u_if.mem_rsp_valid_i = 1'b0;
        repeat (3) @(negedge clock);
        chk("late_rsp_m_rdata", m_rdata_o, 32'h0);
        bus_manual = 0;
        rsp_enable = 1;

        // Normal operation resumes after the abandoned transaction.
        load("post_lw", F3_LW, 32'h8000_0040, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h8000_0134);

        repeat (5) @(negedge clock);
        chk("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
